seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the core combinational ALU for the integer execute stage.
- Executes the existing logic, add/sub and shift operations with one cycle of latency.
- Adds an arithmetic right shift and iterative unsigned multiply, divide and remainder operations that take multiple cycles.
- Uses a valid/ready request port and a single-cycle result-valid strobe, so the pipeline control stalls on in_ready.

Parameters:
- DATA_W, 32: operand and result width in bits. Must be 8 or more and a power of 2.
- SH_W, log2(DATA_W): shift amount width, taken from the low bits of in_1.
- CNT_W, log2(DATA_W)+1: width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle if in_valid is also 1.
- op  in  4  operation code: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 ADDS, 5 ADDU, 6 SUBS, 7 SUBU, 8 SHRL, 9 SHLL, 10 SHRA, 11 MULU, 12 DIVU, 13 REMU. Codes 14 and 15 act as NOP.
- in_0  in  DATA_W  operand 0.
- in_1  in  DATA_W  operand 1.
- flush  in  1  abort any multi-cycle operation in flight.
- out  out  DATA_W  registered result.
- out_valid  out  1  one-cycle strobe that qualifies out, of and dz.
- of  out  1  overflow flag.
- dz  out  1  divide-by-zero flag.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE and the counter clears.
  - out=0, out_valid=0, of=0, dz=0.
  - Any operation in flight is discarded.
  - in_ready is 0 during the reset cycle.
- States: IDLE, RUN.
  - in_ready = (state==IDLE) && reset && !flush.
  - A request is accepted on an edge where in_valid && in_ready.
- Single-cycle ops (0-10, 14, 15):
  - Results are registered on the accept edge; out_valid=1 for exactly the next cycle.
  - Back-to-back accepts are allowed, giving one result per cycle.
  - AND/OR/XOR: bitwise. NOP: out=in_0.
  - ADD*/SUB*: modulo 2^DATA_W.
  - SHRL: logical right shift by in_1[SH_W-1:0]; SHLL: logical left shift by the same amount.
  - SHRA: arithmetic right shift, sign-filling from in_0[DATA_W-1].
- Overflow:
  - ADDS: of=1 iff in_0 and in_1 have the same sign bit and the result sign differs.
  - SUBS: of=1 iff the operand sign bits differ and the result sign differs from in_0.
  - Zero operands are handled by sign bits, not by magnitude compare.
  - MULU: of=1 iff the upper DATA_W bits of the 2*DATA_W-bit product are nonzero.
  - All other ops: of=0.
- Multi-cycle ops (MULU, DIVU, REMU with in_1!=0):
  - On accept: latch operands and op, counter=0, state goes to RUN, in_ready=0.
  - In RUN, one iteration per cycle:
    - MULU: shift-add over the 2*DATA_W-bit product.
    - DIVU/REMU: restoring division, one quotient bit per cycle.
  - After DATA_W iterations (counter reaches DATA_W-1 and increments), state returns to IDLE.
  - out_valid pulses on the following cycle, so latency from the accept edge to the out_valid cycle is DATA_W+1 cycles.
  - in_ready returns to 1 in the same cycle as out_valid.
  - Results: MULU gives the low product; DIVU gives the quotient; REMU gives the remainder.
- Divide by zero (DIVU/REMU with in_1==0):
  - No RUN phase; single-cycle latency with dz=1.
  - DIVU gives out = all ones; REMU gives out = in_0.
  - dz=0 for every other result.
- flush:
  - In RUN: next state is IDLE, no out_valid is produced, and the datapath registers are don't-care.
  - In IDLE: blocks acceptance that cycle. A single-cycle result accepted on the previous edge still strobes.
  - flush with reset==0: reset wins.
- Between strobes, out, of and dz hold their last values; out_valid=0.
- in_valid while in_ready==0: no effect. The requester must hold the request.

Test Plan:
- DATA_W=32, after reset: ADDS 0x7FFFFFFF + 0x00000001 -> next cycle out=0x80000000, of=1, out_valid pulse of 1 cycle. Then SUBS 0x00000000 - 0x80000000 -> out=0x80000000, of=1.
- Back-to-back single-cycle requests AND, SHRA(0x80000000, 4), SHLL(1, 31) -> 3 consecutive out_valid cycles with 0x(a&b), 0xF8000000, 0x80000000. in_ready stays 1 throughout.
- MULU 0x00010000 * 0x00010000 -> out_valid exactly 33 cycles after accept, out=0, of=1. MULU 12345 * 678 -> out=8369910, of=0. in_ready=0 for 32 cycles.
- DIVU 100 / 7 -> out=14 after 33 cycles. REMU 100 / 7 -> out=2. DIVU 5 / 0 -> next cycle out=0xFFFFFFFF, dz=1. REMU 5 / 0 -> out=5, dz=1.
- Abort: assert flush 10 cycles into a DIVU -> no out_valid; in_ready=1 the cycle after flush drops; a following ADDU 2+3 -> out=5.
- Reset mid-operation: drive reset=0 during a MULU RUN -> outputs zeroed and no stray out_valid afterwards. Then reset=1 and run DIVU 9/3 -> out=3 after 33 cycles.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered integer ALU with iterative multiply/divide behind a valid/ready port
module seq_alu #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W),
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic              flush,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              of,
    output logic              dz
);
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_ADDS = 4'd4;
    localparam logic [3:0] OP_ADDU = 4'd5;
    localparam logic [3:0] OP_SUBS = 4'd6;
    localparam logic [3:0] OP_SUBU = 4'd7;
    localparam logic [3:0] OP_SHRL = 4'd8;
    localparam logic [3:0] OP_SHLL = 4'd9;
    localparam logic [3:0] OP_SHRA = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] hi, lo, b;
    logic [DATA_W-1:0] sum, dif, res, hi_n, lo_n;
    logic [DATA_W:0]   madd, trial;
    logic              res_of, res_dz, multi, is_mul;
    logic [SH_W-1:0]   sh;

    assign in_ready = (state == IDLE) && reset && !flush;
    assign sh       = in_1[SH_W-1:0];
    assign multi    = (op == OP_MULU) || ((op == OP_DIVU || op == OP_REMU) && in_1 != '0);
    assign is_mul   = op_q == OP_MULU;

    // single-cycle result and flags; DIVU/REMU here only cover the divide-by-zero case
    always_comb begin
        sum    = in_0 + in_1;
        dif    = in_0 - in_1;
        res    = in_0;
        res_of = 1'b0;
        res_dz = 1'b0;
        case (op)
            OP_AND:  res = in_0 & in_1;
            OP_OR:   res = in_0 | in_1;
            OP_XOR:  res = in_0 ^ in_1;
            OP_ADDS: begin
                res    = sum;
                res_of = (in_0[DATA_W-1] == in_1[DATA_W-1]) && (sum[DATA_W-1] != in_0[DATA_W-1]);
            end
            OP_ADDU: res = sum;
            OP_SUBS: begin
                res    = dif;
                res_of = (in_0[DATA_W-1] != in_1[DATA_W-1]) && (dif[DATA_W-1] != in_0[DATA_W-1]);
            end
            OP_SUBU: res = dif;
            OP_SHRL: res = in_0 >> sh;
            OP_SHLL: res = in_0 << sh;
            OP_SHRA: res = $unsigned($signed(in_0) >>> sh);
            OP_DIVU: begin
                res    = '1;
                res_dz = 1'b1;
            end
            OP_REMU: begin
                res    = in_0;
                res_dz = 1'b1;
            end
            default: res = in_0;
        endcase
    end

    // one iteration step: shift-add multiply over {hi,lo}, or restoring divide with hi=remainder, lo=quotient
    always_comb begin
        madd  = {1'b0, hi} + ({1'b0, b} & {(DATA_W+1){lo[0]}});
        trial = {hi, lo[DATA_W-1]} - {1'b0, b};
        hi_n  = is_mul ? madd[DATA_W:1]
              : trial[DATA_W] ? {hi[DATA_W-2:0], lo[DATA_W-1]} : trial[DATA_W-1:0];
        lo_n  = is_mul ? {madd[0], lo[DATA_W-1:1]} : {lo[DATA_W-2:0], ~trial[DATA_W]};
    end

    // control FSM plus registered datapath and outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            hi        <= '0;
            lo        <= '0;
            b         <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            of        <= 1'b0;
            dz        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == RUN) begin
                if (flush) begin
                    state <= IDLE;
                end else begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        out       <= (op_q == OP_REMU) ? hi_n : lo_n;
                        of        <= is_mul && (hi_n != '0);
                        dz        <= 1'b0;
                    end
                end
            end else if (in_valid && in_ready) begin
                if (multi) begin
                    state <= RUN;
                    cnt   <= '0;
                    op_q  <= op;
                    hi    <= '0;
                    lo    <= (op == OP_MULU) ? in_1 : in_0;
                    b     <= (op == OP_MULU) ? in_0 : in_1;
                end else begin
                    out       <= res;
                    of        <= res_of;
                    dz        <= res_dz;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at DATA_W=32
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, flush;
    logic [3:0]   op;
    logic [W-1:0] in_0, in_1;
    logic         in_ready, out_valid, of, dz;
    logic [W-1:0] out;
    int           checks = 0;
    int           errors = 0;

    seq_alu #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in_0(in_0), .in_1(in_1), .flush(flush),
        .out(out), .out_valid(out_valid), .of(of), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] c);
        in_valid = v;
        op       = o;
        in_0     = a;
        in_1     = c;
    endtask

    // accepts one multi-cycle request and waits (bounded) for its strobe; lat counts cycles from the accept cycle
    task automatic run_multi(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] c, output int lat, output int busy);
        drive(1'b1, o, a, c);
        step();
        in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (out !== '0) begin errors++; $display("FAIL rst_out: got %h want 0", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if ({of, dz} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {of, dz}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b want 1", in_ready); end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 4'd4, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, of, out} !== {1'b1, 1'b1, 32'h8000_0000}) begin errors++; $display("FAIL adds_ovf: got v=%b of=%b out=%h want v=1 of=1 out=80000000", out_valid, of, out); end
        step();
        checks++; if ({out_valid, of, out} !== {1'b0, 1'b1, 32'h8000_0000}) begin errors++; $display("FAIL hold: got v=%b of=%b out=%h want v=0 of=1 out=80000000", out_valid, of, out); end
        drive(1'b1, 4'd6, 32'h0000_0000, 32'h8000_0000);
        step();
        checks++; if ({out_valid, of, out} !== {1'b1, 1'b1, 32'h8000_0000}) begin errors++; $display("FAIL subs_ovf: got v=%b of=%b out=%h want v=1 of=1 out=80000000", out_valid, of, out); end
        drive(1'b1, 4'd6, 32'h0000_0005, 32'h0000_0007);
        step();
        checks++; if ({of, out} !== {1'b0, 32'hFFFF_FFFE}) begin errors++; $display("FAIL subs_neg: got of=%b out=%h want of=0 out=fffffffe", of, out); end
        drive(1'b1, 4'd5, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        checks++; if ({of, out} !== {1'b0, 32'h0000_0000}) begin errors++; $display("FAIL addu_wrap: got of=%b out=%h want of=0 out=0", of, out); end
        drive(1'b1, 4'd7, 32'h0000_0000, 32'h0000_0001);
        step();
        checks++; if ({of, out} !== {1'b0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL subu_wrap: got of=%b out=%h want of=0 out=ffffffff", of, out); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ops  [7] = '{4'd1, 4'd10, 4'd9, 4'd8, 4'd2, 4'd3, 4'd15};
        logic [W-1:0] a    [7] = '{32'hF0F0_A5A5, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h1200_0034, 32'hFFFF_0000, 32'hDEAD_BEEF};
        logic [W-1:0] c    [7] = '{32'h0FF0_FF00, 32'h0000_0004, 32'h0000_001F, 32'h0000_0024, 32'h0034_0012, 32'h0F0F_0F0F, 32'h1234_5678};
        logic [W-1:0] want [7] = '{32'h00F0_A500, 32'hF800_0000, 32'h8000_0000, 32'h0800_0000, 32'h1234_0036, 32'hF0F0_0F0F, 32'hDEAD_BEEF};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ops[i], a[i], c[i]);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            step();
            checks++; if ({out_valid, of, dz, out} !== {3'b100, want[i]}) begin errors++; $display("FAIL b2b_out[%0d]: got v=%b of=%b dz=%b out=%h want v=1 of=0 dz=0 out=%h", i, out_valid, of, dz, out, want[i]); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", out_valid); end
    endtask

    task automatic test_mul();
        int lat, busy;
        run_multi(4'd11, 32'h0001_0000, 32'h0001_0000, lat, busy);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_lat: got %0d want 33", lat); end
        checks++; if (busy !== 32) begin errors++; $display("FAIL mul_busy: got %0d want 32", busy); end
        checks++; if ({out_valid, of, out} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL mul_big: got v=%b of=%b out=%h want v=1 of=1 out=0", out_valid, of, out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_strobe_len: got %b want 0", out_valid); end
        run_multi(4'd11, 32'd12345, 32'd678, lat, busy);
        checks++; if ({lat, of, out} !== {32'd33, 1'b0, 32'd8369910}) begin errors++; $display("FAIL mul_small: got lat=%0d of=%b out=%0d want lat=33 of=0 out=8369910", lat, of, out); end
        run_multi(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy);
        checks++; if ({of, out} !== {1'b1, 32'h0000_0001}) begin errors++; $display("FAIL mul_max: got of=%b out=%h want of=1 out=00000001", of, out); end
        step();
    endtask

    task automatic test_div();
        int lat, busy;
        drive(1'b1, 4'd12, 32'd5, 32'd0);
        step();
        checks++; if ({out_valid, dz, of, out} !== {3'b110, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divz: got v=%b dz=%b of=%b out=%h want v=1 dz=1 of=0 out=ffffffff", out_valid, dz, of, out); end
        drive(1'b1, 4'd13, 32'd5, 32'd0);
        step();
        checks++; if ({out_valid, dz, out} !== {2'b11, 32'd5}) begin errors++; $display("FAIL remz: got v=%b dz=%b out=%h want v=1 dz=1 out=5", out_valid, dz, out); end
        in_valid = 1'b0;
        step();
        run_multi(4'd12, 32'd100, 32'd7, lat, busy);
        checks++; if ({lat, busy, dz, out} !== {32'd33, 32'd32, 1'b0, 32'd14}) begin errors++; $display("FAIL divu: got lat=%0d busy=%0d dz=%b out=%0d want lat=33 busy=32 dz=0 out=14", lat, busy, dz, out); end
        run_multi(4'd13, 32'd100, 32'd7, lat, busy);
        checks++; if ({lat, dz, out} !== {32'd33, 1'b0, 32'd2}) begin errors++; $display("FAIL remu: got lat=%0d dz=%b out=%0d want lat=33 dz=0 out=2", lat, dz, out); end
        run_multi(4'd12, 32'hFFFF_FFFF, 32'd1, lat, busy);
        checks++; if (out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_one: got %h want ffffffff", out); end
        run_multi(4'd13, 32'hFFFF_FFFF, 32'h0000_0010, lat, busy);
        checks++; if (out !== 32'h0000_000F) begin errors++; $display("FAIL remu_max: got %h want 0000000f", out); end
        run_multi(4'd12, 32'hFFFF_FFFF, 32'h8000_0001, lat, busy);
        checks++; if (out !== 32'h0000_0001) begin errors++; $display("FAIL divu_bigdiv: got %h want 00000001", out); end
        step();
    endtask

    task automatic test_flush();
        int strobes = 0;
        drive(1'b1, 4'd12, 32'd1000, 32'd3);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_run: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL flush_stray: got %0d strobes want 0", strobes); end
        drive(1'b1, 4'd5, 32'd2, 32'd3);
        step();
        drive(1'b1, 4'd5, 32'd7, 32'd1);
        flush = 1'b1;
        #1;
        checks++; if ({out_valid, out} !== {1'b1, 32'd5}) begin errors++; $display("FAIL addu_after_flush: got v=%b out=%0d want v=1 out=5", out_valid, out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b want 0", in_ready); end
        step();
        checks++; if ({out_valid, out} !== {1'b0, 32'd5}) begin errors++; $display("FAIL flush_idle_block: got v=%b out=%0d want v=0 out=5", out_valid, out); end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int lat, busy;
        int strobes = 0;
        drive(1'b1, 4'd13, 32'd9, 32'd0);
        step();
        drive(1'b1, 4'd11, 32'd12345, 32'd678);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        flush = 1'b1;
        step();
        checks++; if ({out_valid, of, dz, out} !== {3'b000, 32'h0}) begin errors++; $display("FAIL rst_mid: got v=%b of=%b dz=%b out=%h want all 0", out_valid, of, dz, out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
        reset = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL rst_mid_stray: got %0d strobes want 0", strobes); end
        run_multi(4'd12, 32'd9, 32'd3, lat, busy);
        checks++; if ({lat, out} !== {32'd33, 32'd3}) begin errors++; $display("FAIL div_after_rst: got lat=%0d out=%0d want lat=33 out=3", lat, out); end
        step();
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        in_0     = '0;
        in_1     = '0;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
